// File: rtl/sdram_rw_scheduler.sv
// Round-robin write/read burst scheduler between the dual-clock FIFOs and the SDRAM command core.
// Defining SDRAM_RW_SCHED_WDOG_EN adds a request-to-ack watchdog with a sticky error flag.
module sdram_rw_scheduler #(
    parameter int FIFO_AW     = 10,
    parameter int RDF_DEPTH   = 1024,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic               clk_ref,
    input  logic               rst,
    input  logic               sdram_init_done,
    input  logic [8:0]         wr_length,
    input  logic [8:0]         rd_length,
    input  logic [21:0]        wr_addr,
    input  logic [21:0]        wr_max_addr,
    input  logic [21:0]        rd_addr,
    input  logic [21:0]        rd_max_addr,
    input  logic               wr_load,
    input  logic               rd_load,
    input  logic               rd_en,
    input  logic [FIFO_AW-1:0] wrf_usedw,
    input  logic [FIFO_AW-1:0] rdf_usedw,
    output logic               sdram_wr_req,
    output logic               sdram_rd_req,
    input  logic               sdram_wr_ack,
    input  logic               sdram_rd_ack,
    output logic [21:0]        sdram_wraddr,
    output logic [21:0]        sdram_rdaddr,
    output logic               busy,
    output logic               wr_wrap,
    output logic               rd_wrap,
    output logic               wdog_err
);

    localparam int SW = FIFO_AW + 1;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST, GAP} state_t;

    state_t        state_q, state_d;
    logic          last_wr_q, last_wr_d;
    logic [21:0]   wraddr_q, wraddr_d, rdaddr_q, rdaddr_d;
    logic          pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic          wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
    logic          wr_elig, rd_elig, wr_load_now, rd_load_now, wdog_hit;
    logic [SW-1:0] rd_sum;
    logic [22:0]   wr_next, rd_next;

    assign rd_sum  = SW'(rdf_usedw) + SW'(rd_length);
    assign wr_elig = sdram_init_done && (wr_length != 9'd0) && (SW'(wrf_usedw) >= SW'(wr_length));
    assign rd_elig = sdram_init_done && rd_en && (rd_length != 9'd0) && (rd_sum <= SW'(RDF_DEPTH));

`ifdef SDRAM_RW_SCHED_WDOG_EN
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_err_q, wdog_err_d;

    assign wdog_hit = (wdog_cnt_q == 16'(WDOG_CYCLES - 1));
    assign wdog_err = wdog_err_q;

    always_comb begin
        wdog_cnt_d = 16'd0;
        wdog_err_d = wdog_err_q;
        if (state_q == WR_REQ || state_q == RD_REQ) begin
            wdog_cnt_d = wdog_cnt_q + 16'd1;
            if (wdog_hit && !((state_q == WR_REQ) ? sdram_wr_ack : sdram_rd_ack))
                wdog_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            wdog_cnt_q <= 16'd0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

    // Round robin: with both sides eligible, the side not granted last wins.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: begin
                if (wr_elig && (!rd_elig || !last_wr_q)) state_d = WR_REQ;
                else if (rd_elig)                         state_d = RD_REQ;
            end
            WR_REQ: begin
                if (sdram_wr_ack) begin
                    state_d   = WR_BURST;
                    last_wr_d = 1'b1;
                end else if (wdog_hit) begin
                    state_d = GAP;
                end
            end
            WR_BURST: if (!sdram_wr_ack) state_d = GAP;
            RD_REQ: begin
                if (sdram_rd_ack) begin
                    state_d   = RD_BURST;
                    last_wr_d = 1'b0;
                end else if (wdog_hit) begin
                    state_d = GAP;
                end
            end
            RD_BURST: if (!sdram_rd_ack) state_d = GAP;
            default:  state_d = IDLE;
        endcase
    end

    // A load arriving during the channel's own request/burst waits for burst end and beats the wrap.
    always_comb begin
        wr_load_now = wr_load | pend_wr_q;
        wr_next     = {1'b0, wraddr_q} + 23'(wr_length);
        wraddr_d    = wraddr_q;
        pend_wr_d   = pend_wr_q;
        wr_wrap_d   = 1'b0;
        if (state_q == WR_REQ || state_q == WR_BURST) begin
            pend_wr_d = wr_load_now;
            if (state_q == WR_BURST && !sdram_wr_ack) begin
                pend_wr_d = 1'b0;
                if (wr_load_now) begin
                    wraddr_d = wr_addr;
                end else if (wr_next >= {1'b0, wr_max_addr}) begin
                    wraddr_d  = wr_addr;
                    wr_wrap_d = 1'b1;
                end else begin
                    wraddr_d = wr_next[21:0];
                end
            end
        end else if (wr_load_now) begin
            wraddr_d  = wr_addr;
            pend_wr_d = 1'b0;
        end
    end

    always_comb begin
        rd_load_now = rd_load | pend_rd_q;
        rd_next     = {1'b0, rdaddr_q} + 23'(rd_length);
        rdaddr_d    = rdaddr_q;
        pend_rd_d   = pend_rd_q;
        rd_wrap_d   = 1'b0;
        if (state_q == RD_REQ || state_q == RD_BURST) begin
            pend_rd_d = rd_load_now;
            if (state_q == RD_BURST && !sdram_rd_ack) begin
                pend_rd_d = 1'b0;
                if (rd_load_now) begin
                    rdaddr_d = rd_addr;
                end else if (rd_next >= {1'b0, rd_max_addr}) begin
                    rdaddr_d  = rd_addr;
                    rd_wrap_d = 1'b1;
                end else begin
                    rdaddr_d = rd_next[21:0];
                end
            end
        end else if (rd_load_now) begin
            rdaddr_d  = rd_addr;
            pend_rd_d = 1'b0;
        end
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            wraddr_q  <= 22'd0;
            rdaddr_q  <= 22'd0;
            pend_wr_q <= 1'b0;
            pend_rd_q <= 1'b0;
            wr_wrap_q <= 1'b0;
            rd_wrap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            wraddr_q  <= wraddr_d;
            rdaddr_q  <= rdaddr_d;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            wr_wrap_q <= wr_wrap_d;
            rd_wrap_q <= rd_wrap_d;
        end
    end

    // Request drops in the same cycle the ack arrives.
    assign sdram_wr_req = (state_q == WR_REQ) && !sdram_wr_ack;
    assign sdram_rd_req = (state_q == RD_REQ) && !sdram_rd_ack;
    assign sdram_wraddr = wraddr_q;
    assign sdram_rdaddr = rdaddr_q;
    assign busy         = (state_q != IDLE);
    assign wr_wrap      = wr_wrap_q;
    assign rd_wrap      = rd_wrap_q;

endmodule

// File: tb/tb_sdram_rw_scheduler.sv
// Bench for sdram_rw_scheduler: eligibility vector table plus scoreboarded burst sequences.
module tb_sdram_rw_scheduler;

    logic        clk_ref = 1'b0;
    logic        rst = 1'b1;
    logic        sdram_init_done = 1'b0;
    logic [8:0]  wr_length = '0, rd_length = '0;
    logic [21:0] wr_addr = '0, wr_max_addr = '0, rd_addr = '0, rd_max_addr = '0;
    logic        wr_load = 1'b0, rd_load = 1'b0, rd_en = 1'b0;
    logic [9:0]  wrf_usedw = '0, rdf_usedw = '0;
    logic        sdram_wr_req, sdram_rd_req;
    logic        sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
    logic [21:0] sdram_wraddr, sdram_rdaddr;
    logic        busy, wr_wrap, rd_wrap, wdog_err;

    sdram_rw_scheduler #(.FIFO_AW(10), .RDF_DEPTH(1024), .WDOG_CYCLES(16)) dut (
        .clk_ref(clk_ref), .rst(rst), .sdram_init_done(sdram_init_done),
        .wr_length(wr_length), .rd_length(rd_length),
        .wr_addr(wr_addr), .wr_max_addr(wr_max_addr), .rd_addr(rd_addr), .rd_max_addr(rd_max_addr),
        .wr_load(wr_load), .rd_load(rd_load), .rd_en(rd_en),
        .wrf_usedw(wrf_usedw), .rdf_usedw(rdf_usedw),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .sdram_wraddr(sdram_wraddr), .sdram_rdaddr(sdram_rdaddr),
        .busy(busy), .wr_wrap(wr_wrap), .rd_wrap(rd_wrap), .wdog_err(wdog_err)
    );

    always #5 clk_ref = ~clk_ref;

    int total = 0;
    int bad   = 0;
    int wr_wrap_cnt = 0;

    always @(negedge clk_ref) if (wr_wrap) wr_wrap_cnt++;

    typedef struct {
        bit          is_wr;
        logic [21:0] addr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit         init;
        bit         ren;
        logic [8:0] wl;
        logic [8:0] rl;
        logic [9:0] wu;
        logic [9:0] ru;
        bit         ewr;
        bit         erd;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_ref);
            #2;
        end
    endtask

    task automatic reset_hold();
        rst = 1'b1;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        wr_load = 1'b0;
        rd_load = 1'b0;
        step(1);
    endtask

    // Acts as the SDRAM core: waits for a request, checks it against the scoreboard, runs the ack phase.
    task automatic serve(input int load_at);
        int   n;
        int   len;
        bit   is_wr;
        exp_t e;
        n = 0;
        while (!sdram_wr_req && !sdram_rd_req && n < 100) begin
            step(1);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL req_timeout: no request within 100 cycles at %0t", $time);
            return;
        end
        is_wr = sdram_wr_req;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant: wr=%0d with empty scoreboard", is_wr);
            return;
        end
        e = sb.pop_front();
        chk("grant_channel", 32'(is_wr), 32'(e.is_wr));
        chk("grant_addr", 32'(is_wr ? sdram_wraddr : sdram_rdaddr), 32'(e.addr));
        len = is_wr ? int'(wr_length) : int'(rd_length);
        if (is_wr) sdram_wr_ack = 1'b1;
        else       sdram_rd_ack = 1'b1;
        for (int i = 0; i < len; i++) begin
            step(1);
            wr_load = (i == load_at);
        end
        wr_load = 1'b0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int hi;
        vt[0] = '{1'b0, 1'b1, 9'd8,   9'd8,   10'd100, 10'd0,    1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 9'd256, 9'd8,   10'd256, 10'd0,    1'b1, 1'b0};
        vt[2] = '{1'b1, 1'b0, 9'd256, 9'd8,   10'd255, 10'd0,    1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 9'd0,   9'd8,   10'd100, 10'd0,    1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 9'd8,   9'd256, 10'd0,   10'd900,  1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 9'd8,   9'd256, 10'd0,   10'd768,  1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b1, 9'd8,   9'd256, 10'd0,   10'd769,  1'b0, 1'b0};
        vt[7] = '{1'b1, 1'b1, 9'd8,   9'd8,   10'd8,   10'd0,    1'b1, 1'b0};
        vt[8] = '{1'b1, 1'b1, 9'd8,   9'd0,   10'd0,   10'd0,    1'b0, 1'b0};
        vt[9] = '{1'b1, 1'b1, 9'd8,   9'd1,   10'd0,   10'd1023, 1'b0, 1'b1};

        // reset state, with inputs that would otherwise be eligible
        sdram_init_done = 1'b1; wr_length = 9'd8; wrf_usedw = 10'd100; wr_addr = 22'h55; wr_load = 1'b1;
        step(2);
        chk("reset_ctrl", {26'd0, sdram_wr_req, sdram_rd_req, busy, wr_wrap, rd_wrap, wdog_err}, 32'd0);
        chk("reset_addr", {10'd0, sdram_wraddr | sdram_rdaddr}, 32'd0);
        wr_load = 1'b0;

        // eligibility table, each vector from a fresh reset
        for (int v = 0; v < 10; v++) begin
            reset_hold();
            sdram_init_done = vt[v].init; rd_en = vt[v].ren;
            wr_length = vt[v].wl; rd_length = vt[v].rl;
            wrf_usedw = vt[v].wu; rdf_usedw = vt[v].ru;
            wr_max_addr = 22'h3FFFFF; rd_max_addr = 22'h3FFFFF;
            rst = 1'b0;
            step(2);
            chk($sformatf("vec%0d_req", v), {30'd0, sdram_wr_req, sdram_rd_req}, {30'd0, vt[v].ewr, vt[v].erd});
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vt[v].ewr | vt[v].erd));
        end

        // single 256-word write burst
        reset_hold();
        sdram_init_done = 1'b1; rd_en = 1'b0; wr_length = 9'd256; wrf_usedw = 10'd256;
        wr_addr = 22'd0; wr_max_addr = 22'h3FFFFF;
        rst = 1'b0;
        sb.push_back('{1'b1, 22'd0});
        serve(-1);
        wrf_usedw = 10'd0;
        step(1);
        chk("burst1_gap_busy", 32'(busy), 32'd1);
        chk("burst1_wraddr", 32'(sdram_wraddr), 32'd256);
        step(1);
        chk("burst1_idle_busy", 32'(busy), 32'd0);

        // round-robin alternation, W first after reset
        reset_hold();
        sdram_init_done = 1'b1; rd_en = 1'b1; wr_length = 9'd8; rd_length = 9'd8;
        wrf_usedw = 10'd1000; rdf_usedw = 10'd0;
        wr_addr = 22'd0; rd_addr = 22'd0; wr_max_addr = 22'h3FFFFF; rd_max_addr = 22'h3FFFFF;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{1'b1, 22'(8 * k)});
            sb.push_back('{1'b0, 22'(8 * k)});
        end
        for (int k = 0; k < 8; k++) serve(-1);
        sdram_init_done = 1'b0;
        step(4);
        chk("rr_final_busy", 32'(busy), 32'd0);
        chk("rr_final_addrs", {sdram_wraddr[15:0], sdram_rdaddr[15:0]}, {16'd32, 16'd32});

        // wrap at wr_max_addr
        reset_hold();
        sdram_init_done = 1'b1; rd_en = 1'b0; wr_length = 9'd256; wrf_usedw = 10'd1000;
        wr_addr = 22'd0; wr_max_addr = 22'd512;
        rst = 1'b0;
        base = wr_wrap_cnt;
        sb.push_back('{1'b1, 22'd0});
        sb.push_back('{1'b1, 22'd256});
        serve(-1);
        serve(-1);
        sdram_init_done = 1'b0;
        step(1);
        chk("wrap_wraddr", 32'(sdram_wraddr), 32'd0);
        chk("wrap_pulse_now", 32'(wr_wrap), 32'd1);
        step(2);
        chk("wrap_pulse_count", 32'(wr_wrap_cnt - base), 32'd1);

        // load during burst overrides increment, no wrap
        reset_hold();
        sdram_init_done = 1'b1; rd_en = 1'b0; wr_length = 9'd256; wrf_usedw = 10'd1000;
        wr_addr = 22'h1000; wr_max_addr = 22'd200;
        rst = 1'b0;
        base = wr_wrap_cnt;
        sb.push_back('{1'b1, 22'd0});
        serve(10);
        sdram_init_done = 1'b0;
        step(1);
        chk("load_mid_wraddr", 32'(sdram_wraddr), 32'h1000);
        step(2);
        chk("load_mid_nowrap", 32'(wr_wrap_cnt - base), 32'd0);
        wr_addr = 22'h2000; wr_load = 1'b1;
        step(1);
        wr_load = 1'b0;
        chk("load_idle_wraddr", 32'(sdram_wraddr), 32'h2000);

        // read FIFO headroom boundary
        reset_hold();
        sdram_init_done = 1'b1; rd_en = 1'b1; rd_length = 9'd256; rdf_usedw = 10'd900; wrf_usedw = 10'd0;
        rst = 1'b0;
        step(3);
        chk("rdf900_no_req", 32'(sdram_rd_req), 32'd0);
        rdf_usedw = 10'd768;
        step(1);
        chk("rdf768_req", 32'(sdram_rd_req), 32'd1);

        // reset mid-burst
        reset_hold();
        sdram_init_done = 1'b1; rd_en = 1'b0; wr_length = 9'd8; wrf_usedw = 10'd100;
        wr_addr = 22'h55; wr_max_addr = 22'h3FFFFF; wr_load = 1'b1;
        rst = 1'b0;
        step(1);
        wr_load = 1'b0;
        chk("rstmid_req_addr", {9'd0, sdram_wr_req, sdram_wraddr}, {9'd0, 1'b1, 22'h55});
        sdram_wr_ack = 1'b1;
        step(3);
        rst = 1'b1;
        #1;
        chk("rstmid_state", {9'd0, busy, sdram_wraddr}, 32'd0);
        sdram_wr_ack = 1'b0;
        sdram_init_done = 1'b0;
        step(1);

        // request without ack
        reset_hold();
        sdram_init_done = 1'b1; rd_en = 1'b0; wr_length = 9'd8; wrf_usedw = 10'd100;
        rst = 1'b0;
`ifdef SDRAM_RW_SCHED_WDOG_EN
        step(1);
        hi = 0;
        while (sdram_wr_req && hi < 100) begin
            hi++;
            step(1);
        end
        chk("wdog_req_cycles", 32'(hi), 32'd16);
        step(20);
        chk("wdog_err_sticky", 32'(wdog_err), 32'd1);
        reset_hold();
        chk("wdog_err_rst", 32'(wdog_err), 32'd0);
        rst = 1'b0;
`else
        hi = 0;
        step(40);
        chk("noack_req_held", {30'd0, sdram_wr_req, wdog_err}, 32'd2);
`endif
        sdram_init_done = 1'b0;
        reset_hold();
        rst = 1'b0;

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
